fib_iter_counter: RTL and testbench
===================================

Name: fib_iter_counter

Overview:
Parametrised iteration counter for the Fibonacci datapath. It loads the requested index n, decrements once per accepted step and flags "less-than-threshold" (lt) when the base case is reached. It runs a small load/run/done state machine so the sequencer gets busy and done handshakes instead of driving the decrement combinationally. It replaces the fixed 3-bit decrement/compare slice with a registered block of configurable width and threshold.

Parameters:
WIDTH, 3, width of n and the count register (legal range 2..16).
THR0, 2, lt threshold when mode=0 (Fibonacci base case n<2).
THR1, 1, lt threshold when mode=1 (count-to-zero).
Constraint: 1 <= THR0, THR1 <= 2**WIDTH-1. Violations are caught by an elaboration-time check.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
ld  in  1  load request; samples n and mode.
n  in  WIDTH  start value.
mode  in  1  threshold select, captured on ld.
step  in  1  decrement request.
cnt  out  WIDTH  current count (registered).
lt  out  1  cnt < selected threshold (combinational from registers only).
busy  out  1  high in RUN.
done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (async assert, sync release): cnt=0, mode_q=0, state=IDLE, busy=0, done=0. lt=1 because 0 < THR0.
- Threshold: thr = mode_q ? THR1 : THR0. lt = (cnt < thr), unsigned compare at WIDTH bits.
- States: IDLE, RUN, DONE. Outputs: busy=(state==RUN), done=(state==DONE).
- IDLE:
  - ld=1 -> cnt<=n, mode_q<=mode, next RUN.
  - step is ignored.
- RUN, evaluated in priority order:
  - ld=1 -> reload cnt and mode_q, stay RUN, no done.
  - else lt=1 -> next DONE, cnt held, step ignored.
  - else step=1 -> cnt<=cnt-1, stay RUN.
  - else hold.
- DONE (lasts exactly one cycle):
  - ld=1 -> load and go to RUN; done is still high this cycle.
  - else -> IDLE.
- Latency:
  - ld at edge t -> cnt=n and busy=1 visible after t.
  - The cycle lt first reads 1 in RUN -> done=1 the following cycle, busy=0 in that same cycle.
- No wrap-around: a decrement happens only while cnt >= thr >= 1, so cnt never underflows. cnt holds its final value after done and until the next ld.
- Step gaps: cnt holds, no penalty, no timeout.
- Simultaneous ld+step: ld wins and the step is dropped.
- Reset mid-operation: immediate return to the reset values; no done pulse is emitted.
- Loading n < thr: no decrement occurs; done follows after one RUN cycle.

Decomposition:
- Shared package fib_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - default WIDTH;
  - default thresholds FIB_THR_BASE=2 and FIB_THR_ZERO=1.
- One natural sub-module, fib_lt_cmp: combinational WIDTH-bit unsigned less-than with a threshold mux on mode_q.
- The counter and FSM stay in the top module.

Test Plan (WIDTH=3, THR0=2, THR1=1):
1. Assert rst for 2 cycles, then release -> cnt=0, busy=0, done=0, lt=1. No transitions while ld=0, even with step=1.
2. ld with n=5, mode=0, then step=1 every cycle -> cnt sequence 5,4,3,2,1. lt rises at cnt=1, done pulses one cycle later for exactly 1 cycle, busy falls with done. Total of 4 decrements; cnt stays 1 afterwards.
3. ld with n=3, mode=1, step toggled 1,0,1,0,... -> cnt 3,3,2,2,1,1,0 (holds on step=0). lt at cnt=0, done pulse follows, cnt never wraps to 7.
4. ld with n=1, mode=0, step held high -> cnt=1 and lt=1 on the first RUN cycle, done on the next cycle, cnt stays 1 (no decrement). Repeat with n=0 -> same response.
5. Run started with n=6, mode=0. At cnt=3, assert ld with n=7 and mode=1, with step also high -> next cycle cnt=7 (step dropped), busy stays 1, no done. The run then ends at cnt=0 with lt computed against THR1.
6. Assert rst asynchronously mid-RUN at cnt=4, between clock edges -> cnt=0 and busy=0 without waiting for a clock edge, no done pulse. After release, ld with n=2 starts a clean run.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci iteration counter: state encoding,
// default width and the two lt thresholds.
package fib_pkg;

  localparam int FIB_WIDTH    = 3;
  localparam int FIB_THR_BASE = 2;
  localparam int FIB_THR_ZERO = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_t;

  // True when a threshold is representable and non-zero at the given width.
  function automatic bit fib_thr_ok(input int width, input int thr);
    return (thr >= 1) && (thr <= ((1 << width) - 1));
  endfunction

endpackage

// File: rtl/fib_lt_cmp.sv
// Unsigned WIDTH-bit "count below threshold" compare; the threshold is
// picked by the captured mode bit.
module fib_lt_cmp
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int THR0  = FIB_THR_BASE,
  parameter int THR1  = FIB_THR_ZERO
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             mode_q,
  output logic             lt
);

  localparam logic [WIDTH-1:0] THR0_V = WIDTH'(THR0);
  localparam logic [WIDTH-1:0] THR1_V = WIDTH'(THR1);

  logic [WIDTH-1:0] thr;

  assign thr = mode_q ? THR1_V : THR0_V;
  assign lt  = (cnt < thr);

endmodule

// File: rtl/fib_iter_counter.sv
// Registered iteration counter for the Fibonacci sequencer: load n, count
// down on step, and report completion through a busy/done handshake.
module fib_iter_counter
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int THR0  = FIB_THR_BASE,
  parameter int THR1  = FIB_THR_ZERO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] n,
  input  logic             mode,
  input  logic             step,
  output logic [WIDTH-1:0] cnt,
  output logic             lt,
  output logic             busy,
  output logic             done
);

  if ((WIDTH < 2) || (WIDTH > 16)) begin : g_bad_width
    $error("fib_iter_counter: WIDTH must lie in 2..16");
  end
  if (!fib_thr_ok(WIDTH, THR0)) begin : g_bad_thr0
    $error("fib_iter_counter: THR0 must lie in 1..2**WIDTH-1");
  end
  if (!fib_thr_ok(WIDTH, THR1)) begin : g_bad_thr1
    $error("fib_iter_counter: THR1 must lie in 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  fib_state_t state;
  logic       mode_q;

  fib_lt_cmp #(
    .WIDTH (WIDTH),
    .THR0  (THR0),
    .THR1  (THR1)
  ) u_lt_cmp (
    .cnt    (cnt),
    .mode_q (mode_q),
    .lt     (lt)
  );

  // Handshake: ld is taken on any clock edge outside reset and always beats
  // step; step is taken only in RUN while ld=0 and lt=0, and busy marks the
  // cycles in which a step can be taken. done is a one-cycle completion
  // pulse, and busy/done are registered copies of the RUN/DONE states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld) begin
            cnt    <= n;
            mode_q <= mode;
            state  <= RUN;
            busy   <= 1'b1;
            done   <= 1'b0;
          end
        end
        RUN: begin
          if (ld) begin
            cnt    <= n;
            mode_q <= mode;
          end else if (lt) begin
            // Base case reached: hold cnt so the sequencer can read it.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (step) begin
            cnt <= cnt - ONE;
          end
        end
        DONE: begin
          if (ld) begin
            cnt    <= n;
            mode_q <= mode;
            state  <= RUN;
            busy   <= 1'b1;
            done   <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_iter_counter.sv
// Bench for fib_iter_counter (WIDTH=3, THR0=2, THR1=1): directed scenarios
// with literal expectations, then random traffic against a behavioural model.
module tb_fib_iter_counter;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         ld;
  logic [W-1:0] n;
  logic         mode;
  logic         step;
  logic [W-1:0] cnt;
  logic         lt;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: the loaded value, the captured mode and which phase
  // of the job (0 idle, 1 counting, 2 finishing) the counter is in.
  int m_cnt   = 0;
  int m_mode  = 0;
  int m_phase = 0;

  fib_iter_counter #(
    .WIDTH (W),
    .THR0  (2),
    .THR1  (1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .n    (n),
    .mode (mode),
    .step (step),
    .cnt  (cnt),
    .lt   (lt),
    .busy (busy),
    .done (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int thr_of(input int md);
    return (md != 0) ? 1 : 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a job starts (or restarts) on ld, finishes once the count
  // is below the mode's threshold, and otherwise counts down on step.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   = 0;
      m_mode  = 0;
      m_phase = 0;
    end else if (ld) begin
      m_cnt   = int'(n);
      m_mode  = int'(mode);
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (m_cnt < thr_of(m_mode)) m_phase = 2;
      else if (step)              m_cnt   = m_cnt - 1;
    end else begin
      m_phase = 0;
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    chk("cnt",  int'(cnt),  m_cnt);
    chk("lt",   int'(lt),   (m_cnt < thr_of(m_mode)) ? 1 : 0);
    chk("busy", int'(busy), (m_phase == 1) ? 1 : 0);
    chk("done", int'(done), (m_phase == 2) ? 1 : 0);
  end

  // driver tasks
  task automatic drive(input logic l, input logic [W-1:0] nn, input logic md, input logic st);
    ld   = l;
    n    = nn;
    mode = md;
    step = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int exp2 [6];
    int exp3 [7];
    exp2 = '{5, 4, 3, 2, 1, 1};
    exp3 = '{3, 3, 2, 2, 1, 1, 0};

    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // 1: reset state, no transitions without ld
    chk("rst_cnt",  int'(cnt),  0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_lt",   int'(lt),   1);
    drive(1'b0, 3'd5, 1'b0, 1'b1);
    repeat (3) tick();
    chk("idle_step_cnt",  int'(cnt),  0);
    chk("idle_step_busy", int'(busy), 0);

    // 2: n=5 mode 0, continuous step
    drive(1'b1, 3'd5, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b1);
      chk("t2_cnt", int'(cnt), exp2[i]);
      chk("t2_done", int'(done), (i == 5) ? 1 : 0);
    end
    chk("t2_lt_end", int'(lt), 1);
    tick();
    chk("t2_done_one_cycle", int'(done), 0);
    chk("t2_hold_cnt", int'(cnt), 1);

    // 3: n=3 mode 1, step toggling
    drive(1'b1, 3'd3, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      drive(1'b0, 3'd0, 1'b0, (i % 2) == 1);
      chk("t3_cnt", int'(cnt), exp3[i]);
    end
    chk("t3_lt", int'(lt), 1);
    tick();
    chk("t3_done", int'(done), 1);
    chk("t3_no_wrap", int'(cnt), 0);
    tick();

    // 4: n below threshold, then n=0
    for (int k = 1; k >= 0; k--) begin
      drive(1'b1, W'(k), 1'b0, 1'b1);
      tick();
      drive(1'b0, 3'd0, 1'b0, 1'b1);
      chk("t4_cnt_run", int'(cnt), k);
      chk("t4_lt_run", int'(lt), 1);
      tick();
      chk("t4_done", int'(done), 1);
      chk("t4_cnt_done", int'(cnt), k);
      tick();
    end

    // 5: reload mid-run with ld+step together
    drive(1'b1, 3'd6, 1'b0, 1'b1);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    repeat (3) tick();
    chk("t5_pre_cnt", int'(cnt), 3);
    drive(1'b1, 3'd7, 1'b1, 1'b1);
    tick();
    chk("t5_reload_cnt", int'(cnt), 7);
    chk("t5_reload_busy", int'(busy), 1);
    chk("t5_reload_done", int'(done), 0);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    repeat (7) tick();
    chk("t5_end_cnt", int'(cnt), 0);
    chk("t5_end_lt", int'(lt), 1);
    tick();
    chk("t5_done", int'(done), 1);
    tick();

    // 6: asynchronous reset mid-run
    drive(1'b1, 3'd6, 1'b0, 1'b1);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    repeat (2) tick();
    chk("t6_pre_cnt", int'(cnt), 4);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_cnt", int'(cnt), 0);
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_done", int'(done), 0);
    tick();
    rst = 1'b0;
    drive(1'b1, 3'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    chk("t6_load_cnt", int'(cnt), 2);
    tick();
    chk("t6_step_cnt", int'(cnt), 1);
    tick();
    chk("t6_done", int'(done), 1);
    tick();

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 7) == 0, W'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
